// File: rtl/mem_arbiter.sv
// Two-master to one-target memory arbiter with latched target-side request.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed priority.
module mem_arbiter #(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_wdata,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_wdata,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            s_cyc,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_wdata,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack,
    output logic [1:0]      grant
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t          r_state;
    logic            r_cyc;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW/8-1:0] r_sel;
    logic [DW-1:0]   r_wdata;
    logic [1:0]      r_grant;
    logic            r_m0_ack;
    logic            r_m1_ack;
    logic [DW-1:0]   r_m0_rdata;
    logic [DW-1:0]   r_m1_rdata;

    logic w_hold;
    logic w_el0;
    logic w_el1;
    logic w_pick1;

    // Arbitrate only after an ack retires, so ties see both requesters.
    assign w_hold = r_m0_ack | r_m1_ack;
    assign w_el0  = m0_req & ~r_m0_ack & ~w_hold;
    assign w_el1  = m1_req & ~r_m1_ack & ~w_hold;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic r_last;
    assign w_pick1 = w_el1 & (~w_el0 | ~r_last);
`else
    assign w_pick1 = w_el1 & ~w_el0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_sel      <= '0;
            r_wdata    <= '0;
            r_grant    <= 2'b00;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            r_last     <= 1'b1;
`endif
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_el0 | w_el1) begin
                        r_state <= w_pick1 ? BUSY1 : BUSY0;
                        r_cyc   <= 1'b1;
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                        r_we    <= w_pick1 ? m1_we : m0_we;
                        r_addr  <= w_pick1 ? m1_addr : m0_addr;
                        r_sel   <= w_pick1 ? m1_sel : m0_sel;
                        r_wdata <= w_pick1 ? m1_wdata : m0_wdata;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        r_last  <= w_pick1;
`endif
                    end
                end
                BUSY0: begin
                    if (s_ack) begin
                        r_state    <= IDLE;
                        r_cyc      <= 1'b0;
                        r_grant    <= 2'b00;
                        r_m0_ack   <= 1'b1;
                        r_m0_rdata <= s_rdata;
                    end
                end
                BUSY1: begin
                    if (s_ack) begin
                        r_state    <= IDLE;
                        r_cyc      <= 1'b0;
                        r_grant    <= 2'b00;
                        r_m1_ack   <= 1'b1;
                        r_m1_rdata <= s_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_cyc    = r_cyc;
    assign s_we     = r_we;
    assign s_addr   = r_addr;
    assign s_sel    = r_sel;
    assign s_wdata  = r_wdata;
    assign grant    = r_grant;
    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard of acks,
// and hand sequences for stale-request, spurious ack, reset and ties.
module tb_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [3:0]    m0_sel, m1_sel, s_sel;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic          m0_ack, m1_ack;
    logic          s_cyc, s_we, s_ack;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [1:0]    grant;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr),
        .s_sel(s_sel), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    sel;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        int            waitc;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vt[6];
    logic [1:0] tie_exp[4];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (m0_ack || m1_ack)) begin
            if (m0_ack && m1_ack) chk("dual_ack", 1, 0);
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {m1_ack, m0_ack}, 0);
            end else begin
                e = sbq.pop_front();
                chk("ack_port", {m1_ack, m0_ack}, e.port ? 2'b10 : 2'b01);
                chk("ack_rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    task automatic drive(input bit p, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [3:0] sel,
                         input logic [31:0] wd);
        if (!p) begin
            m0_req = req; m0_we = we; m0_addr = a;
            m0_sel = sel; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a;
            m1_sel = sel; m1_wdata = wd;
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    // Called at a negedge; returns at a negedge one cycle after the ack.
    task automatic run_vec(input vec_t v);
        logic [1:0] oh;
        oh = v.port ? 2'b10 : 2'b01;
        drive(!v.port, 0, 0, '0, 4'h0, 32'h0);
        drive(v.port, 1, v.we, v.addr, v.sel, v.wdata);
        @(negedge clk);
        chk("grant_lat", grant, oh);
        chk("s_cyc_on", s_cyc, 1);
        chk("s_fields", {s_we, s_addr, s_sel, s_wdata},
            {v.we, v.addr, v.sel, v.wdata});
        for (int i = 0; i < v.waitc; i++) begin
            drive(v.port, 1, ~v.we, ~v.addr, ~v.sel, 32'hFFFF);
            @(negedge clk);
            chk("s_hold", {s_we, s_addr, s_sel, s_wdata},
                {v.we, v.addr, v.sel, v.wdata});
            chk("grant_hold", grant, oh);
        end
        s_ack = 1'b1;
        s_rdata = v.rdata;
        sbq.push_back('{port: v.port, rdata: v.rdata});
        @(negedge clk);
        s_ack = 1'b0;
        s_rdata = $urandom;
        chk("idle_after_ack", {s_cyc, grant}, 0);
        chk("nonowner_ack", v.port ? m0_ack : m1_ack, 0);
        drive(v.port, 0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("ack_one_cycle", {m1_ack, m0_ack}, 0);
        chk("rdata_hold", v.port ? m1_rdata : m0_rdata, v.rdata);
    endtask

    initial begin
        bit ok;
        vt[0] = '{port: 0, we: 0, addr: 30'h10, sel: 4'hF,
                  wdata: 32'h0, rdata: 32'hCAFEF00D, waitc: 1};
        vt[1] = '{port: 1, we: 1, addr: 30'h20, sel: 4'h3,
                  wdata: 32'h1234, rdata: 32'h0, waitc: 2};
        vt[2] = '{port: 0, we: 1, addr: 30'h3FFFFFFF, sel: 4'h1,
                  wdata: 32'hDEADBEEF, rdata: 32'h55AA55AA, waitc: 0};
        vt[3] = '{port: 1, we: 0, addr: 30'h0, sel: 4'hF,
                  wdata: 32'h0, rdata: 32'hFFFFFFFF, waitc: 3};
        vt[4] = '{port: 0, we: 0, addr: 30'h2AAAAAAA, sel: 4'h0,
                  wdata: 32'h0, rdata: 32'h0, waitc: 0};
        vt[5] = '{port: 1, we: 0, addr: 30'h99, sel: 4'hC,
                  wdata: 32'h0, rdata: 32'h600DCAFE, waitc: 1};
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b10;
        tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b01;
        tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif
        drive(0, 0, 0, '0, 4'h0, 32'h0);
        drive(1, 0, 0, '0, 4'h0, 32'h0);
        s_ack = 1'b0;
        s_rdata = 32'h0;
        #12;
        chk("rst_ctrl", {s_cyc, s_we, grant, m0_ack, m1_ack}, 0);
        chk("rst_addr", {s_addr, s_sel}, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Stale request: m0 keeps req through the cycle after its ack.
        drive(0, 1, 0, 30'h5, 4'hF, 32'h0);
        @(negedge clk);
        chk("stale_grant", grant, 2'b01);
        s_ack = 1'b1;
        s_rdata = 32'h77;
        sbq.push_back('{port: 0, rdata: 32'h77});
        @(negedge clk);
        s_ack = 1'b0;
        @(negedge clk);
        chk("stale_masked", {s_cyc, grant}, 0);
        drive(0, 0, 0, '0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_no_regrant", s_cyc, 0);
        end

        // Spurious target ack while idle.
        s_ack = 1'b1;
        s_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("spurious", {m0_ack, m1_ack, s_cyc, grant}, 0);
        end
        s_ack = 1'b0;
        run_vec(vt[0]);

        // Reset while BUSY0 with s_ack pending.
        drive(0, 1, 0, 30'h44, 4'hF, 32'h0);
        @(negedge clk);
        chk("rst_mid_grant", grant, 2'b01);
        s_ack = 1'b1;
        s_rdata = 32'h12345678;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {s_cyc, grant}, 0);
        chk("rst_addr_clr", s_addr, 0);
        drive(0, 0, 0, '0, 4'h0, 32'h0);
        s_ack = 1'b0;
        @(negedge clk);
        chk("rst_no_ack", {m0_ack, m1_ack}, 0);
        chk("rst_rdata0", m0_rdata, 0);
        rst_n = 1'b1;
        run_vec(vt[5]);

        // Tie with both requests held continuously.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 30'h100, 4'hF, 32'h0);
        drive(1, 1, 0, 30'h200, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_grant(ok);
            chk("tie_grant", grant, tie_exp[i]);
            s_ack = 1'b1;
            s_rdata = 32'h100 + i;
            sbq.push_back('{port: grant[1], rdata: 32'h100 + i});
            @(negedge clk);
            s_ack = 1'b0;
        end
        drive(0, 0, 0, '0, 4'h0, 32'h0);
        drive(1, 0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("tie_end_idle", {s_cyc, grant}, 0);
        @(negedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 30, meaning word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for each requester k in {0,1}, the following ports; port 0 is the CPU data port and port 1 the secondary master (debug/DMA):
- mk_req  input  1  request, held high until mk_ack is seen.
- mk_we  input  1  1 = write.
- mk_addr  input  AW  word address.
- mk_sel  input  DW/8  byte enables.
- mk_wdata  input  DW  write data.
- mk_rdata  output  DW  read data, valid while mk_ack is high.
- mk_ack  output  1  one-cycle completion pulse.
REQ-006 SHALL have target-side ports:
- s_cyc  output  1  transaction active.
- s_we  output  1  latched we.
- s_addr  output  AW  latched address.
- s_sel  output  DW/8  latched byte enables.
- s_wdata  output  DW  latched write data.
- s_rdata  input  DW  target read data.
- s_ack  input  1  target completion.
REQ-007 SHALL have port grant  output  2  one-hot owner; 00 when idle.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY0 and BUSY1.
REQ-009 In IDLE, a requester k is eligible when mk_req=1 and mk_ack=0; this masks the stale request in the cycle following an ack.
REQ-010 In IDLE with any eligible requester, the FSM SHALL move to BUSYk on the next edge, latching that requester's we/addr/sel/wdata into the s_* registers.
- s_cyc=1 and grant=one-hot(k) from the cycle after req is sampled, i.e. 1-cycle grant latency.
REQ-011 While in BUSYk, s_* outputs SHALL hold constant; changes on mk_* inputs SHALL be ignored.
REQ-012 On an edge where state=BUSYk and s_ack=1, the FSM SHALL:
- return to IDLE, with s_cyc=0 and grant=00;
- drive mk_ack=1 for exactly the next cycle;
- drive mk_rdata = s_rdata captured at that edge.
REQ-013 mk_rdata SHALL hold its last captured value otherwise; it is updated for both reads and writes.
REQ-014 s_ack while IDLE SHALL be ignored, with no ack to either requester.
REQ-015 A requester dropping mk_req while BUSY on its behalf SHALL NOT abort the transaction; mk_ack still pulses.
REQ-016 Minimum back-to-back throughput SHALL be one transaction per 3 cycles per requester (grant, s_ack, ack/idle); a different eligible requester MAY be granted in the IDLE cycle in which the other's ack is high.
REQ-017 The non-owner's mk_ack SHALL remain 0 throughout.
REQ-018 Arbitration on simultaneous eligible requests SHALL be as defined under Configuration.

Reset
REQ-019 rst_n=0 SHALL immediately, without a clock edge, force:
- state=IDLE;
- s_cyc=0, s_we=0, s_addr=0, s_sel=0, s_wdata=0;
- grant=00;
- m0_ack=m1_ack=0, m0_rdata=m1_rdata=0;
- last-grant register=1.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no ack issued; the first edge after release SHALL evaluate IDLE normally.

Configuration
REQ-021 Macro MEM_ARBITER_ROUND_ROBIN_EN SHALL select the arbitration policy:
- Defined: round-robin. A 1-bit last-grant register is updated on each grant; on a tie the requester not granted last wins. The first tie after reset goes to port 0.
- Undefined: fixed priority, port 0 always wins ties, and no last-grant register is synthesised.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Single read: m0_req=1, m0_we=0, m0_addr=0x10 at edge 0 -> s_cyc=1, s_addr=0x10 from edge 1. Target acks at edge 3 with s_rdata=0xCAFEF00D -> m0_ack=1 and m0_rdata=0xCAFEF00D for exactly one cycle after edge 3; s_cyc=0.
- Write latch: m1 write addr=0x20, sel=0x3, wdata=0x1234; the bench changes m1_wdata to 0xFFFF while BUSY1 -> s_wdata stays 0x1234 until ack.
- Tie, macro defined: both req held high continuously -> grant sequence 01,10,01,10 and acks alternate. Macro undefined -> grant 01 every transaction and m1 starves.
- Stale-request mask: m0 holds req one cycle past m0_ack, m1 idle -> exactly one s_cyc transaction for m0.
- Reset mid-op: rst_n low while BUSY0 with s_ack pending -> s_cyc and grant drop asynchronously and no m0_ack appears. After release, a new m1 request completes normally.
- Spurious ack: s_ack=1 while IDLE -> m0_ack=m1_ack=0 and state remains IDLE.
